// File: rtl/picorv_mem_arbiter_pkg.sv
// Shared types and constants for the picorv32 native memory port arbiter.
//   ADDR_W / DATA_W / STRB_W : native port field widths
//   arb_state_e              : arbiter FSM states
//   DEFAULT_ERR_DATA         : rdata returned on a watchdog timeout
package picorv_mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/picorv_mem_arbiter_if.sv
// Bundle of N picorv32-style native memory ports (flattened per lane).
//   valid[N]            : request, held until ready
//   addr/wdata/wstrb    : lane i at [W*i +: W]; wstrb==0 means read
//   ready[N]            : one-cycle completion pulse
//   rdata               : read data, shared by all lanes
// master modport drives the request side, slave modport answers it.
interface picorv_mem_arbiter_if
    import picorv_mem_pkg::*;
#(
    parameter int unsigned N = 1
);
    logic [N-1:0]        valid;
    logic [N*ADDR_W-1:0] addr;
    logic [N*DATA_W-1:0] wdata;
    logic [N*STRB_W-1:0] wstrb;
    logic [N-1:0]        ready;
    logic [DATA_W-1:0]   rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/picorv_mem_arbiter_rr_pick.sv
// Combinational rotate-priority picker.
//   req_i   : request mask
//   ptr_i   : highest-priority index (must be < N)
//   grant_o : first set request searching upward from ptr_i, wrapping at N
//   any_o   : at least one request present
module picorv_rr_pick #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] grant_o,
    output logic          any_o
);

    always_comb begin : pick
        int unsigned idx;
        idx     = 0;
        grant_o = '0;
        any_o   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            // explicit wrap so non-power-of-two N never indexes past N-1
            idx = 32'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_o && req_i[IW'(idx)]) begin
                any_o   = 1'b1;
                grant_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/picorv_mem_arbiter.sv
// Round-robin arbiter sharing one picorv32 native memory port between
// NUM_REQ requesters, holding the grant for one full transaction. A
// watchdog completes a transaction stuck for TIMEOUT cycles with ERR_DATA.
//   clk, rst     : clock, synchronous active-high reset
//   m_if         : requester side (slave modport), NUM_REQ lanes
//   s_if         : shared slave side (master modport), one lane
//   err_sticky_o : set on any timeout
//   err_id_o     : requester of the first timeout since last clear
//   err_clr_i    : clears err_sticky_o / err_id_o (a same-cycle timeout wins)
module picorv_mem_arbiter
    import picorv_mem_pkg::*;
#(
    parameter  int unsigned       NUM_REQ  = 2,
    parameter  int unsigned       TIMEOUT  = 1024,
    parameter  logic [DATA_W-1:0] ERR_DATA = DEFAULT_ERR_DATA,
    localparam int unsigned       IW       = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    picorv_mem_arbiter_if.slave  m_if,
    picorv_mem_arbiter_if.master s_if,
    output logic                 err_sticky_o,
    output logic [IW-1:0]        err_id_o,
    input  logic                 err_clr_i
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    localparam logic [0:0] ST_IDLE = ARB_IDLE;
    localparam logic [0:0] ST_BUSY = ARB_BUSY;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] g_q, g_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_sticky_q, err_sticky_d;
    logic [IW-1:0] err_id_q, err_id_d;

    logic [IW-1:0] pick_grant;
    logic          pick_any;
    logic          busy;
    logic          timeout_hit;
    logic          done;

    picorv_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i   (m_if.valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .any_o   (pick_any)
    );

    assign busy        = (state_q == ST_BUSY);
    // s_ready on the last allowed cycle is a normal completion
    assign timeout_hit = busy && (cnt_q == CW'(TIMEOUT - 1)) && !s_if.ready[0];
    assign done        = busy && (s_if.ready[0] || timeout_hit);

    assign s_if.valid = busy;
    assign s_if.addr  = busy ? m_if.addr[g_q*ADDR_W +: ADDR_W]   : '0;
    assign s_if.wdata = busy ? m_if.wdata[g_q*DATA_W +: DATA_W] : '0;
    assign s_if.wstrb = busy ? m_if.wstrb[g_q*STRB_W +: STRB_W] : '0;

    assign m_if.ready = done ? (NUM_REQ'(1) << g_q) : '0;
    assign m_if.rdata = (busy && s_if.ready[0]) ? s_if.rdata :
                        timeout_hit             ? ERR_DATA   : '0;

    assign err_sticky_o = err_sticky_q;
    assign err_id_o     = err_id_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        g_d          = g_q;
        cnt_d        = cnt_q;
        err_sticky_d = err_sticky_q;
        err_id_d     = err_id_q;

        if (err_clr_i) begin
            err_sticky_d = 1'b0;
            err_id_d     = '0;
        end
        if (timeout_hit) begin
            err_sticky_d = 1'b1;
            // keep the first offender unless this same cycle also clears
            if (!err_sticky_q || err_clr_i) begin
                err_id_d = g_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    g_d     = pick_grant;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (done) begin
                    ptr_d   = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            g_q          <= '0;
            cnt_q        <= '0;
            err_sticky_q <= 1'b0;
            err_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            g_q          <= g_d;
            cnt_q        <= cnt_d;
            err_sticky_q <= err_sticky_d;
            err_id_q     <= err_id_d;
        end
    end

endmodule
